irq_arb: RTL and testbench

IRQ_ARB -- requirements
Module: irq_arb

---
 rtl/irq_arb.sv | 180 ++++++++++++++++++
 tb/tb_irq_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arb.sv
// Edge-triggered interrupt arbiter with mask, global enable and CPU ack/EOI handshake.
// Define IRQ_ARB_RR_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module irq_arb #(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned VEC_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] irq_i,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_d,
   input  logic             gie,
   input  logic             cpu_ack,
   input  logic             eoi,
   output logic             irq_o,
   output logic [VEC_W-1:0] vec_o,
   output logic [N_SRC-1:0] src_clr_o,
   output logic [N_SRC-1:0] pend_o,
   output logic [N_SRC-1:0] mask_o
);

   localparam int unsigned DBL_W = 2 * N_SRC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      REQ  = 2'd2,
      SVC  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [N_SRC-1:0]   irq_prev_q;
   logic               arm_q;
   logic [N_SRC-1:0]   pend_q, pend_d;
   logic [N_SRC-1:0]   msk_q, msk_d;
   logic               irq_req_q, irq_req_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [N_SRC-1:0]   clr_q, clr_d;
   logic [N_SRC-1:0]   ack_clr;
   logic [N_SRC-1:0]   rise;
   logic [N_SRC-1:0]   cand;
   logic               win_vld;
   logic [VEC_W-1:0]   win_idx;

   // arm_q blocks a level that is already high at reset release from looking like an edge
   assign rise = irq_i & ~irq_prev_q & {N_SRC{arm_q}};
   assign cand = pend_q & msk_q;

   assign pend_d = (pend_q & ~ack_clr) | rise;
   assign msk_d  = mask_we ? mask_d : msk_q;

`ifdef IRQ_ARB_RR_EN
   logic [VEC_W-1:0]   rr_q, rr_d;
   logic [DBL_W-1:0]   cand_dbl;
   logic [N_SRC-1:0]   cand_rot;
   int unsigned        win_sum;

   // Rotate candidates so the search starts at the pointer, then pick the lowest rotated bit
   always_comb begin
      cand_dbl = {cand, cand} >> rr_q;
      cand_rot = cand_dbl[N_SRC-1:0];
      win_vld  = 1'b0;
      win_idx  = '0;
      win_sum  = 0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (!win_vld && cand_rot[i]) begin
            win_vld = 1'b1;
            win_sum = 32'(rr_q) + 32'(i);
            if (win_sum >= N_SRC) begin
               win_sum = win_sum - N_SRC;
            end
            win_idx = VEC_W'(win_sum);
         end
      end
   end
`else
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (!win_vld && cand[i]) begin
            win_vld = 1'b1;
            win_idx = VEC_W'(i);
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         irq_prev_q <= '0;
         arm_q      <= 1'b0;
         pend_q     <= '0;
         msk_q      <= '0;
         irq_req_q  <= 1'b0;
         vec_q      <= '0;
         clr_q      <= '0;
      end else begin
         state_q    <= state_d;
         irq_prev_q <= irq_i;
         arm_q      <= 1'b1;
         pend_q     <= pend_d;
         msk_q      <= msk_d;
         irq_req_q  <= irq_req_d;
         vec_q      <= vec_d;
         clr_q      <= clr_d;
      end
   end

`ifdef IRQ_ARB_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end
`endif

   // Next-state and output decode; REQ holds the vector regardless of later mask/gie changes
   always_comb begin
      state_d   = state_q;
      irq_req_d = irq_req_q;
      vec_d     = vec_q;
      clr_d     = '0;
      ack_clr   = '0;
`ifdef IRQ_ARB_RR_EN
      rr_d      = rr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (gie && (|cand)) begin
               state_d = ARB;
            end
         end
         ARB: begin
            if (win_vld) begin
               vec_d     = win_idx;
               irq_req_d = 1'b1;
               state_d   = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (cpu_ack) begin
               irq_req_d = 1'b0;
               state_d   = SVC;
               if (32'(vec_q) < N_SRC) begin
                  ack_clr = N_SRC'(1) << vec_q;
                  clr_d   = ack_clr;
`ifdef IRQ_ARB_RR_EN
                  if (32'(vec_q) + 32'd1 >= N_SRC) begin
                     rr_d = '0;
                  end else begin
                     rr_d = vec_q + VEC_W'(1);
                  end
`endif
               end
            end
         end
         SVC: begin
            if (eoi) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign irq_o     = irq_req_q;
   assign vec_o     = vec_q;
   assign src_clr_o = clr_q;
   assign pend_o    = pend_q;
   assign mask_o    = msk_q;

endmodule

// File: tb/tb_irq_arb.sv
// Scoreboard bench for irq_arb: expected vectors are queued with the stimulus and
// popped when the arbiter presents an interrupt. Works with or without IRQ_ARB_RR_EN.
module tb_irq_arb;

   localparam int unsigned N  = 4;
   localparam int unsigned VW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  irq_i;
   logic          mask_we;
   logic [N-1:0]  mask_d;
   logic          gie;
   logic          cpu_ack;
   logic          eoi;
   logic          irq_o;
   logic [VW-1:0] vec_o;
   logic [N-1:0]  src_clr_o;
   logic [N-1:0]  pend_o;
   logic [N-1:0]  mask_o;

   int unsigned   n_chk = 0;
   int unsigned   n_err = 0;
   int unsigned   exp_q[$];

   irq_arb #(.N_SRC(N), .VEC_W(VW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_i     (irq_i),
      .mask_we   (mask_we),
      .mask_d    (mask_d),
      .gie       (gie),
      .cpu_ack   (cpu_ack),
      .eoi       (eoi),
      .irq_o     (irq_o),
      .vec_o     (vec_o),
      .src_clr_o (src_clr_o),
      .pend_o    (pend_o),
      .mask_o    (mask_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_mask(input logic [N-1:0] m);
      mask_d  = m;
      mask_we = 1'b1;
      tick();
      mask_we = 1'b0;
   endtask

   // Wait (bounded) for a request, compare against the scoreboard head, then ack
   task automatic serve(input bit do_eoi);
      int unsigned  e;
      int           n;
      logic [N-1:0] oh;
      n = 0;
      while (!irq_o && n < 20) begin
         tick();
         n++;
      end
      check("irq_up", 32'(irq_o), 32'd1);
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
         return;
      end
      e  = exp_q.pop_front();
      oh = N'(1) << e;
      check("vec", 32'(vec_o), e);
      cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      check("src_clr", 32'(src_clr_o), 32'(oh));
      check("irq_drop", 32'(irq_o), 32'd0);
      tick();
      check("clr_1cyc", 32'(src_clr_o), 32'd0);
      if (do_eoi) begin
         eoi = 1'b1;
         tick();
         eoi = 1'b0;
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] g;
      rst_n   = 1'b0;
      irq_i   = '0;
      mask_we = 1'b0;
      mask_d  = '0;
      gie     = 1'b0;
      cpu_ack = 1'b0;
      eoi     = 1'b0;
      #12;
      check("rst_irq",  32'(irq_o),     32'd0);
      check("rst_vec",  32'(vec_o),     32'd0);
      check("rst_pend", 32'(pend_o),    32'd0);
      check("rst_mask", 32'(mask_o),    32'd0);
      check("rst_clr",  32'(src_clr_o), 32'd0);
      #1 rst_n = 1'b1;
      tick();

      // Single source: two-clock latency from pend to irq_o, one-cycle clear pulse
      wr_mask(4'b1111);
      check("mask_rb", 32'(mask_o), 32'hf);
      gie   = 1'b1;
      irq_i = 4'b0100;
      tick();
      check("t1_pend", 32'(pend_o), 32'h4);
      check("t1_lat0", 32'(irq_o), 32'd0);
      tick();
      check("t1_lat1", 32'(irq_o), 32'd0);
      tick();
      check("t1_lat2", 32'(irq_o), 32'd1);
      exp_q.push_back(2);
      serve(1'b1);
      check("t1_pend_clr", 32'(pend_o), 32'd0);
      irq_i = '0;

      // Simultaneous edges on sources 1 and 3
`ifdef IRQ_ARB_RR_EN
      exp_q.push_back(3);
      exp_q.push_back(1);
`else
      exp_q.push_back(1);
      exp_q.push_back(3);
`endif
      irq_i = 4'b1010;
      serve(1'b1);
      serve(1'b1);
      irq_i = '0;
      tick();

      // Masked source latches pending but is not presented; stray ack/eoi ignored
      wr_mask(4'b1011);
      irq_i = 4'b0100;
      tick();
      check("t3_pend", 32'(pend_o), 32'h4);
      cpu_ack = 1'b1;
      eoi     = 1'b1;
      tick();
      cpu_ack = 1'b0;
      eoi     = 1'b0;
      check("t3_stray_clr", 32'(src_clr_o), 32'd0);
      repeat (3) tick();
      check("t3_masked_irq", 32'(irq_o), 32'd0);
      check("t3_pend_hold", 32'(pend_o), 32'h4);
      wr_mask(4'b1111);
      check("t3_unmask0", 32'(irq_o), 32'd0);
      tick();
      check("t3_unmask1", 32'(irq_o), 32'd0);
      tick();
      check("t3_unmask2", 32'(irq_o), 32'd1);
      exp_q.push_back(2);
      serve(1'b1);

      // New edge in the ack cycle: set wins, source presented again after eoi
      irq_i = 4'b0001;
      tick();
      irq_i = 4'b0000;
      tick();
      tick();
      check("t4_irq", 32'(irq_o), 32'd1);
      check("t4_vec", 32'(vec_o), 32'd0);
      cpu_ack = 1'b1;
      irq_i   = 4'b0001;
      tick();
      cpu_ack = 1'b0;
      check("t4_setwins", 32'(pend_o), 32'h1);
      check("t4_clr", 32'(src_clr_o), 32'h1);
      check("t4_drop", 32'(irq_o), 32'd0);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      exp_q.push_back(0);
      serve(1'b1);
      check("t4_pend_end", 32'(pend_o), 32'd0);

      // Reset asserted mid-request: outputs drop immediately, held levels are not edges
      irq_i = 4'b0101;
      tick();
      tick();
      tick();
      check("t5_req", 32'(irq_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_irq",  32'(irq_o),     32'd0);
      check("t5_rst_pend", 32'(pend_o),    32'd0);
      check("t5_rst_clr",  32'(src_clr_o), 32'd0);
      check("t5_rst_mask", 32'(mask_o),    32'd0);
      tick();
      rst_n = 1'b1;
      wr_mask(4'b1111);
      repeat (5) tick();
      check("t5_no_pend", 32'(pend_o), 32'd0);
      check("t5_no_irq",  32'(irq_o),  32'd0);
      irq_i = '0;
      tick();

      // Sources 0 and 1 re-asserting during service: RR alternates, fixed starves 1
      irq_i = 4'b0011;
`ifdef IRQ_ARB_RR_EN
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(0);
      exp_q.push_back(1);
`else
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
`endif
      for (int k = 0; k < 4; k++) begin
         g = (exp_q.size() != 0) ? 2'(exp_q[0]) : 2'd0;
         serve(1'b0);
         irq_i[g] = 1'b0;
         tick();
         irq_i[g] = 1'b1;
         tick();
         eoi = 1'b1;
         tick();
         eoi = 1'b0;
      end
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
